// File: rtl/s4ga_cfg_tx.sv
// s4ga_cfg_tx: transmit side of the s4ga LUT-configuration stream.
// Takes one packed LUT config per cfg_valid/cfg_ready handshake and
// serializes it into SI_W-bit segments (one per si_valid beat), each
// index/mask field zero-padded to whole segments, MSB segment first.
// A session opens with a single reset beat (fab_rst=1) for the fabric.
//
// Handshake: a config word transfers on any rising clk edge where
// cfg_valid and cfg_ready are both high. cfg_ready never depends on
// cfg_valid; cfg_valid may be raised or dropped freely, and cfg_data is
// only sampled at the transfer edge.
module s4ga_cfg_tx #(
  parameter int N    = 64,
  parameter int K    = 4,
  parameter int SI_W = 4,
  localparam int IDX_W     = $clog2(N),
  localparam int MASK_W    = 2 ** K,
  localparam int IDX_SEGS  = (IDX_W + SI_W - 1) / SI_W,
  localparam int MASK_SEGS = (MASK_W + SI_W - 1) / SI_W,
  localparam int SEGS      = K * IDX_SEGS + MASK_SEGS,
  localparam int CFG_W     = K * IDX_W + MASK_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             enable,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CFG_W-1:0] cfg_data,
  output logic [SI_W-1:0]  si,
  output logic             si_valid,
  output logic             fab_rst,
  output logic [IDX_W-1:0] lut_n,
  output logic             frame_done,
  output logic             busy
);

  localparam int PAD_W  = SEGS * SI_W;
  localparam int SEG_CW = (SEGS > 1) ? $clog2(SEGS) : 1;
  localparam logic [SEG_CW-1:0] SEG_LAST = SEG_CW'(SEGS - 1);
  localparam logic [IDX_W-1:0]  LUT_LAST = IDX_W'(N - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RST_BEAT = 2'd1,
    STREAM   = 2'd2,
    DRAIN    = 2'd3
  } state_t;

  // state is left visible by name so checkers can bind to it directly
  state_t            state;
  logic [CFG_W-1:0]  hold_q;     // word whose segment is on si this cycle
  logic              hold_full;  // hold_q has a segment on si this cycle
  logic [SEG_CW-1:0] seg;        // index of the segment on si this cycle

  logic              last_seg;
  logic              accept;
  logic [CFG_W-1:0]  src_word;
  logic [SEG_CW-1:0] src_seg;
  logic [PAD_W-1:0]  src_pad;
  logic [SI_W-1:0]   next_si;

  // Lay every field out on whole-segment boundaries, zero-extended,
  // idx0 in the most significant segments and the mask last.
  function automatic logic [PAD_W-1:0] pad_cfg(input logic [CFG_W-1:0] w);
    logic [PAD_W-1:0] p;
    p = '0;
    for (int i = 0; i < K; i++) begin
      p[(SEGS - (i + 1) * IDX_SEGS) * SI_W +: IDX_W] =
        w[MASK_W + (K - 1 - i) * IDX_W +: IDX_W];
    end
    p[MASK_W-1:0] = w[MASK_W-1:0];
    return p;
  endfunction

  assign last_seg  = hold_full && (seg == SEG_LAST);
  // Ready when nothing is held, or the held word leaves this cycle, so a
  // new word follows the last segment with no bubble.
  assign cfg_ready = (state == STREAM) && enable && (!hold_full || last_seg);
  assign accept    = cfg_valid && cfg_ready;

  // Pick the segment that goes on si next: segment 0 of a newly accepted
  // word, otherwise the following segment of the held word.
  always_comb begin
    src_word = hold_q;
    src_seg  = '0;
    if (accept) begin
      src_word = cfg_data;
    end else if (seg != SEG_LAST) begin
      src_seg = seg + 1'b1;
    end
    src_pad = pad_cfg(src_word);
    next_si = src_pad[(SEGS - 1 - int'(src_seg)) * SI_W +: SI_W];
  end

  // Session FSM with registered outputs; all state clears asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      hold_q     <= '0;
      hold_full  <= 1'b0;
      seg        <= '0;
      si         <= '0;
      si_valid   <= 1'b0;
      fab_rst    <= 1'b0;
      lut_n      <= '0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      fab_rst    <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          si_valid  <= 1'b0;
          hold_full <= 1'b0;
          busy      <= 1'b0;
          if (start && enable) begin
            state    <= RST_BEAT;
            si       <= '0;
            si_valid <= 1'b1;
            fab_rst  <= 1'b1;
            lut_n    <= '0;
            busy     <= 1'b1;
          end
        end
        RST_BEAT: begin
          state     <= STREAM;
          si_valid  <= 1'b0;
          hold_full <= 1'b0;
          seg       <= '0;
          busy      <= 1'b1;
        end
        STREAM, DRAIN: begin
          if (accept) begin
            hold_q     <= cfg_data;
            hold_full  <= 1'b1;
            seg        <= '0;
            si         <= next_si;
            si_valid   <= 1'b1;
            frame_done <= (SEG_LAST == '0) && (lut_n == LUT_LAST);
          end else if (hold_full && !last_seg) begin
            seg        <= seg + 1'b1;
            si         <= next_si;
            si_valid   <= 1'b1;
            frame_done <= (seg + 1'b1 == SEG_LAST) && (lut_n == LUT_LAST);
          end else begin
            // underflow or end of word: si keeps its last value
            hold_full <= 1'b0;
            si_valid  <= 1'b0;
            seg       <= '0;
          end
          if (last_seg) begin
            lut_n <= (lut_n == LUT_LAST) ? '0 : lut_n + 1'b1;
          end
          if (state == STREAM) begin
            if (!enable) begin
              if (hold_full && !last_seg) begin
                state <= DRAIN;
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end
          end else if (last_seg || !hold_full) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_s4ga_cfg_tx.sv
// tb_s4ga_cfg_tx: scoreboard bench for s4ga_cfg_tx. Drivers push the
// expected beats of each accepted word / reset beat into exp_q; a monitor
// pops and compares on every si_valid beat.
module tb_s4ga_cfg_tx;

  localparam int N         = 64;
  localparam int K         = 4;
  localparam int SI_W      = 4;
  localparam int IDX_W     = 6;
  localparam int MASK_W    = 16;
  localparam int IDX_SEGS  = 2;
  localparam int MASK_SEGS = 4;
  localparam int SEGS      = 12;
  localparam int CFG_W     = 40;
  localparam int EW        = 1 + SI_W + IDX_W + 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             enable = 1'b0;
  logic             cfg_valid = 1'b0;
  logic             cfg_ready;
  logic [CFG_W-1:0] cfg_data = '0;
  logic [SI_W-1:0]  si;
  logic             si_valid;
  logic             fab_rst;
  logic [IDX_W-1:0] lut_n;
  logic             frame_done;
  logic             busy;

  // expected beat: {fab_rst, si, lut_n, frame_done}
  logic [EW-1:0] exp_q[$];
  int            n_checks = 0;
  int            n_fail = 0;
  int            model_lut = 0;
  logic [SI_W-1:0] last_si = '0;
  int            cyc = 0;
  int            win_first = -1;
  int            win_last = -1;
  int            win_beats = 0;

  s4ga_cfg_tx #(.N(N), .K(K), .SI_W(SI_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .enable(enable),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_data(cfg_data),
    .si(si), .si_valid(si_valid), .fab_rst(fab_rst), .lut_n(lut_n),
    .frame_done(frame_done), .busy(busy)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_beat(input int s, input bit last);
    logic [SI_W-1:0] sv;
    logic [IDX_W-1:0] lv;
    sv = SI_W'(s);
    lv = IDX_W'(model_lut);
    exp_q.push_back({1'b0, sv, lv, last && (model_lut == N - 1)});
  endtask

  // Reference: split the word into fields by arithmetic and emit each
  // field's zero-padded base-16 digits, most significant first.
  task automatic push_word(input logic [CFG_W-1:0] w);
    longint unsigned v, f;
    int segs[$];
    v = 64'(w);
    for (int i = 0; i < K; i++) begin
      f = (v >> (MASK_W + (K - 1 - i) * IDX_W)) % N;
      for (int s = 0; s < IDX_SEGS; s++)
        segs.push_back(int'((f >> ((IDX_SEGS - 1 - s) * SI_W)) % (1 << SI_W)));
    end
    f = v % (64'd1 << MASK_W);
    for (int s = 0; s < MASK_SEGS; s++)
      segs.push_back(int'((f >> ((MASK_SEGS - 1 - s) * SI_W)) % (1 << SI_W)));
    for (int j = 0; j < SEGS; j++) push_beat(segs[j], j == SEGS - 1);
    model_lut = (model_lut + 1) % N;
  endtask

  // Directed word: idx0=5, idx1=0x3F, idx2=0, idx3=1, mask=0xBEEF
  task automatic push_directed();
    int tbl[SEGS] = '{0, 5, 3, 15, 0, 0, 0, 1, 11, 14, 14, 15};
    for (int j = 0; j < SEGS; j++) push_beat(tbl[j], j == SEGS - 1);
    model_lut = (model_lut + 1) % N;
  endtask

  // Offer a word until accepted; expectation queued at the transfer edge.
  task automatic drive_word(input logic [CFG_W-1:0] w, input bit directed);
    bit ok = 0;
    cfg_valid = 1'b1;
    cfg_data  = w;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (cfg_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      check("accept_timeout", 32'd0, 32'd1);
    end else if (directed) begin
      push_directed();
    end else begin
      push_word(w);
    end
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    cfg_data  = {$urandom, $urandom};
  endtask

  task automatic do_start();
    start  = 1'b1;
    enable = 1'b1;
    @(negedge clk);
    model_lut = 0;
    exp_q.push_back({1'b1, {SI_W{1'b0}}, {IDX_W{1'b0}}, 1'b0});
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_drain();
    bit ok = 0;
    for (int t = 0; t < 3000; t++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        ok = 1;
        break;
      end
    end
    if (!ok) check("drain_timeout", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic win_reset();
    win_first = -1;
    win_last  = -1;
    win_beats = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_si"}, 32'(si), 32'd0);
    check({tag, "_si_valid"}, 32'(si_valid), 32'd0);
    check({tag, "_fab_rst"}, 32'(fab_rst), 32'd0);
    check({tag, "_cfg_ready"}, 32'(cfg_ready), 32'd0);
    check({tag, "_lut_n"}, 32'(lut_n), 32'd0);
    check({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  // monitor: pop and compare every beat, check si hold between beats
  always @(negedge clk) begin
    logic [EW-1:0] e;
    cyc++;
    if (!rst_n) begin
      last_si = '0;
    end else if (si_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_beat", {20'd0, fab_rst, si, lut_n, frame_done}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("beat", 32'({fab_rst, si, lut_n, frame_done}), 32'(e));
        last_si = e[IDX_W+1 +: SI_W];
      end
      if (!fab_rst) begin
        if (win_first < 0) win_first = cyc;
        win_last = cyc;
        win_beats++;
      end
    end else begin
      check("si_hold", 32'(si), 32'(last_si));
      check("idle_frame_done", 32'(frame_done), 32'd0);
    end
  end

  // stimulus
  initial begin
    // reset state
    #12;
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // start with enable low is ignored
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("start_no_enable_busy", 32'(busy), 32'd0);

    // single directed word
    do_start();
    drive_word({6'd5, 6'h3F, 6'd0, 6'd1, 16'hBEEF}, 1'b1);
    wait_drain();
    check("single_lut_n", 32'(lut_n), 32'(model_lut));

    // close session, then back-to-back full frame plus two words
    enable = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("idle_after_enable_low", 32'(busy), 32'd0);
    do_start();
    win_reset();
    for (int i = 0; i < N + 2; i++) drive_word({$urandom, $urandom}, 1'b0);
    wait_drain();
    check("b2b_beats", 32'(win_beats), 32'((N + 2) * SEGS));
    check("b2b_no_bubble", 32'(win_last - win_first + 1), 32'(win_beats));
    check("b2b_lut_n", 32'(lut_n), 32'(model_lut));

    // underflow: 5 idle cycles between words
    win_reset();
    drive_word({$urandom, $urandom}, 1'b0);
    repeat (SEGS + 4) @(posedge clk);
    #1;
    drive_word({$urandom, $urandom}, 1'b0);
    wait_drain();
    check("underflow_gap", 32'(win_last - win_first + 1 - win_beats), 32'd5);

    // enable dropped while segment 4 is on si
    drive_word({$urandom, $urandom}, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    enable    = 1'b0;
    cfg_valid = 1'b1;
    cfg_data  = {$urandom, $urandom};
    for (int t = 0; t < SEGS - 4; t++) begin
      @(negedge clk);
      check("drain_cfg_ready", 32'(cfg_ready), 32'd0);
      @(posedge clk); #1;
      start  = (t == 1);
      enable = (t == 1);
    end
    start     = 1'b0;
    enable    = 1'b0;
    cfg_valid = 1'b0;
    wait_drain();
    repeat (2) @(posedge clk);
    #1;
    check("drain_busy", 32'(busy), 32'd0);
    check("drain_lut_kept", 32'(lut_n), 32'(model_lut));

    // async reset while segment 7 is on si
    do_start();
    drive_word({$urandom, $urandom}, 1'b0);
    repeat (7) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async");
    exp_q.delete();
    model_lut = 0;
    enable = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_start();
    drive_word({$urandom, $urandom}, 1'b0);
    wait_drain();
    check("post_reset_lut_n", 32'(lut_n), 32'(model_lut));

    // random words with random gaps
    for (int i = 0; i < 20; i++) begin
      drive_word({$urandom, $urandom}, 1'b0);
      repeat ($urandom_range(0, 14)) @(posedge clk);
      #1;
    end
    wait_drain();
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
